// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of the UART receiver: serial line in, byte stream out with a valid/ready pop.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     rx;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     frame_err;
  logic                     overrun;

  // master: line driver and byte consumer; slave: the receiver itself
  modport master (
    output rx, rx_ready,
    input  rx_data, rx_valid, level, frame_err, overrun
  );

  modport slave (
    input  rx, rx_ready,
    output rx_data, rx_valid, level, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with BAUD_DIV oversampling, start/stop framing checks and a
// show-ahead byte FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int unsigned BAUD_DIV = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            s1_q, rxs_q;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic            fe_q, ov_q;

  logic            push_req, fe_set;
  logic            full, pop, push, ov_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      s1_q  <= bus.rx;
      rxs_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    fe_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        // start bit is checked half a bit in so later samples land mid-bit
        if (cnt_q == CW'(BAUD_DIV / 2 - 1)) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // leave at mid stop bit so a back-to-back start edge is not missed
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs_q) push_req = 1'b1;
          else       fe_set   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full   = (level_q == (AW + 1)'(DEPTH));
  assign pop    = (level_q != '0) && bus.rx_ready;
  assign push   = push_req && (!full || pop);
  assign ov_set = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      fe_q <= fe_set;
      ov_q <= ov_set;
    end
  end

  assign bus.rx_data   = mem_q[rd_ptr_q];
  assign bus.rx_valid  = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a bit-level transmitter drives rx, results checked by assertions.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int unsigned BD = 16;
  localparam int unsigned DP = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   fe_cnt;
  int   ov_cnt;
  int   fe_base;
  int   ov_base;
  int   npops;
  logic [7:0] pops [4];

  uart_rx_fifo_if #(.DEPTH(DP)) u_if ();

  uart_rx_fifo #(.BAUD_DIV(BD), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.frame_err === 1'b1) fe_cnt++;
    if (u_if.overrun   === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stopb = 1'b1);
    u_if.rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (BD) @(negedge clk);
    end
    u_if.rx = stopb;
    repeat (BD) @(negedge clk);
    u_if.rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, u_if.rx_valid, 1);
    chk({tag, "_data"},  u_if.rx_data, exp);
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; fe_cnt = 0; ov_cnt = 0;
    rst = 1'b0;
    u_if.rx = 1'b1;
    u_if.rx_ready = 1'b0;
    #5;
    chk("rst_valid", u_if.rx_valid, 0);
    chk("rst_level", u_if.level, 0);
    chk("rst_data",  u_if.rx_data, 0);
    chk("rst_fe",    u_if.frame_err, 0);
    chk("rst_ov",    u_if.overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    // 1: single byte, fixed start-edge-to-valid latency
    fork
      send(8'h41);
      begin
        repeat (154) @(negedge clk);
        chk("t1_valid_154", u_if.rx_valid, 0);
        @(negedge clk);
        chk("t1_valid_155", u_if.rx_valid, 1);
        chk("t1_data",      u_if.rx_data, 8'h41);
        chk("t1_level",     u_if.level, 1);
      end
    join
    idle(4);
    pop_chk("t1_pop", 8'h41);
    chk("t1_level_after", u_if.level, 0);

    // 2: back-to-back frames drained as they arrive
    fe_base = fe_cnt; ov_base = ov_cnt; npops = 0;
    u_if.rx_ready = 1'b1;
    fork
      begin
        send(8'h41);
        send(8'h44);
      end
      begin
        repeat (330) begin
          @(negedge clk);
          if (u_if.rx_valid === 1'b1) begin
            if (npops < 4) pops[npops] = u_if.rx_data;
            npops++;
          end
        end
      end
    join
    u_if.rx_ready = 1'b0;
    chk("t2_npops", npops, 2);
    chk("t2_pop0",  pops[0], 8'h41);
    chk("t2_pop1",  pops[1], 8'h44);
    chk("t2_level", u_if.level, 0);
    chk("t2_fe",    fe_cnt - fe_base, 0);
    chk("t2_ov",    ov_cnt - ov_base, 0);

    // 3: short glitch on idle line
    fe_base = fe_cnt;
    u_if.rx = 1'b0;
    idle(4);
    u_if.rx = 1'b1;
    idle(40);
    chk("t3_level", u_if.level, 0);
    chk("t3_fe",    fe_cnt - fe_base, 0);

    // 4: bad stop bit, then a good frame
    fe_base = fe_cnt;
    send(8'h55, 1'b0);
    idle(20);
    chk("t4_fe",    fe_cnt - fe_base, 1);
    chk("t4_level", u_if.level, 0);
    send(8'hA5);
    idle(5);
    chk("t4_level_good", u_if.level, 1);
    pop_chk("t4_pop", 8'hA5);

    // 5: overflow drops the fifth byte
    ov_base = ov_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i));
    idle(5);
    chk("t5_level", u_if.level, 4);
    chk("t5_ov",    ov_cnt - ov_base, 1);
    pop_chk("t5_pop1", 8'h01);
    pop_chk("t5_pop2", 8'h02);
    pop_chk("t5_pop3", 8'h03);
    pop_chk("t5_pop4", 8'h04);
    chk("t5_level_empty", u_if.level, 0);
    chk("t5_valid_empty", u_if.rx_valid, 0);

    // 6: full FIFO with a pop coinciding with the push
    ov_base = ov_cnt;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
    fork
      send(8'h06);
      begin
        repeat (154) @(negedge clk);
        u_if.rx_ready = 1'b1;
        @(negedge clk);
        u_if.rx_ready = 1'b0;
        chk("t6_ov_flag", u_if.overrun, 0);
        chk("t6_level",   u_if.level, 4);
      end
    join
    idle(5);
    chk("t6_ov", ov_cnt - ov_base, 0);
    pop_chk("t6_pop1", 8'h12);
    pop_chk("t6_pop2", 8'h13);
    pop_chk("t6_pop3", 8'h14);
    pop_chk("t6_pop4", 8'h06);

    // 7: reset mid-frame with a byte already queued
    send(8'h77);
    idle(5);
    chk("t7_pre_level", u_if.level, 1);
    fork
      send(8'h3C);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b0;
        #0.2;
        chk("t7_rst_level", u_if.level, 0);
        chk("t7_rst_valid", u_if.rx_valid, 0);
        chk("t7_rst_data",  u_if.rx_data, 0);
      end
    join
    @(negedge clk);
    rst = 1'b1;
    idle(10);
    fe_base = fe_cnt; ov_base = ov_cnt;
    send(8'h3C);
    idle(5);
    chk("t7_level", u_if.level, 1);
    pop_chk("t7_pop", 8'h3C);
    chk("t7_level_empty", u_if.level, 0);
    chk("t7_fe", fe_cnt - fe_base, 0);
    chk("t7_ov", ov_cnt - ov_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
